// File: rtl/spi_master_if.sv
// spi_master_if: register request/response bus between a requester and spi_master
interface spi_master_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/spi_master.sv
// spi_master: turns one register request into a 40-bit SPI mode-0 frame and returns read data
module spi_master #(
    parameter int CLK_DIV = 2,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    spi_master_if.slave  bus,
    output logic         sclk,
    output logic         cs_n,
    output logic         mosi,
    input  logic         miso
);
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;
    localparam logic [7:0] HALF = 8'(CLK_DIV - 1);
    state_t            state_q, state_d;
    logic [7:0]        half_q, half_d;
    logic [5:0]        bit_q, bit_d;
    logic [39:0]       tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d, rdata_q, rdata_d;
    logic              sclk_q, sclk_d, wr_q, wr_d, rsp_q, rsp_d;
    logic [ADDR_W-1:0] addr;
    assign addr = bus.req_addr;
    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        sclk_d  = sclk_q;
        wr_d    = wr_q;
        rsp_d   = 1'b0;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                state_d = SHIFT;
                half_d  = HALF;
                bit_d   = 6'd39;
                wr_d    = bus.req_write;
                tx_d    = {bus.req_write, 7'b0, 16'(addr), bus.req_write ? bus.req_wdata : 16'h0000};
            end
            SHIFT: if (half_q != 8'd0) begin
                half_d = half_q - 8'd1;
            end else begin
                half_d = HALF;
                sclk_d = !sclk_q;
                // rising edge samples miso; falling edge advances mosi and the bit count
                if (!sclk_q) begin
                    rx_d = {rx_q[DATA_W-2:0], miso};
                end else begin
                    tx_d = {tx_q[38:0], 1'b0};
                    if (bit_q == 6'd0) state_d = HOLD;
                    else bit_d = bit_q - 6'd1;
                end
            end
            HOLD: if (half_q != 8'd0) begin
                half_d = half_q - 8'd1;
            end else begin
                state_d = GAP;
                half_d  = HALF;
                rsp_d   = 1'b1;
                rdata_d = wr_q ? '0 : rx_q;
            end
            GAP: if (half_q != 8'd0) half_d = half_q - 8'd1;
                 else state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            half_q  <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            sclk_q  <= 1'b0;
            wr_q    <= 1'b0;
            rsp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            sclk_q  <= sclk_d;
            wr_q    <= wr_d;
            rsp_q   <= rsp_d;
        end
    end
    assign bus.req_ready = state_q == IDLE;
    assign bus.rsp_valid = rsp_q;
    assign bus.rsp_rdata = rdata_q;
    assign sclk          = sclk_q;
    assign cs_n          = !(state_q == SHIFT || state_q == HOLD);
    assign mosi          = tx_q[39];
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: three spi_master instances (CLK_DIV 2, 1, 3) checked cycle by cycle against a frame-timing model
module tb_spi_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rstn[3], rvalid[3], rwrite[3], rready[3], rsp_valid[3], sclk[3], cs_n[3], mosi[3], miso[3];
    logic [9:0]  raddr[3];
    logic [15:0] rwdata[3], rsp_rdata[3];

    function automatic int div_of(input int i);
        return i == 0 ? 2 : (i == 1 ? 1 : 3);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : u
        spi_master_if bus ();
        assign bus.req_valid = rvalid[g];
        assign bus.req_write = rwrite[g];
        assign bus.req_addr  = raddr[g];
        assign bus.req_wdata = rwdata[g];
        assign rready[g]     = bus.req_ready;
        assign rsp_valid[g]  = bus.rsp_valid;
        assign rsp_rdata[g]  = bus.rsp_rdata;
        spi_master #(.CLK_DIV(div_of(g))) dut (
            .clk(clk), .rst_n(rstn[g]), .bus(bus.slave),
            .sclk(sclk[g]), .cs_n(cs_n[g]), .mosi(mosi[g]), .miso(miso[g])
        );
    end

    int n_chk = 0, n_pass = 0;
    bit busy[3], wr[3], prev_cs[3], prev_sclk[3], prev_mosi[3], prev_rdy[3];
    int c0[3], rises[3], cslow[3], viol[3], acc_at[3], rsp_at[3], rdy_at[3];
    logic [39:0] frame[3], mw[3], mpat[3], col[3];
    logic [15:0] exp_rd[3];

    function automatic void chk(input string nm, input int i, input logic [39:0] act, input logic [39:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", nm, i, cyc, act, exp);
    endfunction

    // Expected pins from acceptance time: bit k occupies 2D cycles starting at 1+2Dk, low half first.
    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            int d, r, k, ph;
            bit e_cs, e_sclk, e_mosi, e_rsp, cm, v, mv;
            d = div_of(i);
            if (prev_cs[i] && !cs_n[i]) begin col[i] = '0; rises[i] = 0; cslow[i] = 0; viol[i] = 0; end
            if (!cs_n[i]) cslow[i]++;
            if (sclk[i] && !prev_sclk[i]) begin col[i] = {col[i][38:0], mosi[i]}; rises[i]++; end
            if (sclk[i] && prev_sclk[i] && mosi[i] != prev_mosi[i]) viol[i]++;
            if (rsp_valid[i]) rsp_at[i] = cyc;
            if (rvalid[i] && rready[i] && rstn[i]) acc_at[i] = cyc;
            if (rready[i] && !prev_rdy[i]) rdy_at[i] = cyc;
            prev_cs[i] = cs_n[i]; prev_sclk[i] = sclk[i]; prev_mosi[i] = mosi[i]; prev_rdy[i] = rready[i];
            if (!rstn[i]) begin busy[i] = 0; exp_rd[i] = '0; end
            r = cyc - c0[i];
            e_cs = 1; e_sclk = 0; e_mosi = 0; e_rsp = 0; cm = 1; mv = 1'($urandom);
            if (busy[i] && r >= 1 && r <= 80 * d) begin
                k = (r - 1) / (2 * d);
                ph = (r - 1) % (2 * d);
                e_cs = 0; e_sclk = ph >= d; e_mosi = frame[i][39 - k];
                // miso carries the true bit only in the last low cycle; inverted elsewhere
                v = mw[i][39 - k];
                mv = (ph == d - 1) ? v : !v;
            end else if (busy[i] && r >= 1 && r <= 81 * d) begin
                e_cs = 0; cm = 0;
            end else if (busy[i] && r == 81 * d + 1) begin
                e_rsp = 1;
                exp_rd[i] = wr[i] ? 16'h0 : mw[i][15:0];
            end
            if (busy[i] && r > 82 * d) busy[i] = 0;
            chk("req_ready", i, rready[i], !busy[i]);
            chk("cs_n", i, cs_n[i], e_cs);
            chk("sclk", i, sclk[i], e_sclk);
            if (cm) chk("mosi", i, mosi[i], e_mosi);
            chk("rsp_valid", i, rsp_valid[i], e_rsp);
            chk("rsp_rdata", i, rsp_rdata[i], exp_rd[i]);
            if (!busy[i] && rvalid[i] && rstn[i]) begin
                busy[i] = 1; c0[i] = cyc; wr[i] = rwrite[i]; mw[i] = mpat[i];
                frame[i] = {rwrite[i] ? 8'h80 : 8'h00, 6'h0, raddr[i], rwrite[i] ? rwdata[i] : 16'h0};
            end
            miso[i] = mv;
        end
    endtask

    task automatic cycle_();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic int ev(input int i, input int w);
        return w == 0 ? acc_at[i] : (w == 1 ? rsp_at[i] : rdy_at[i]);
    endfunction

    task automatic wait_ev(input int i, input int w);
        for (int n = 0; n < 1000 && ev(i, w) < 0; n++) cycle_();
        if (ev(i, w) < 0) chk("timeout", i, ev(i, w) >= 0, 1);
    endtask

    task automatic xfer(input int i, input bit w, input logic [9:0] a, input logic [15:0] d, input logic [15:0] md);
        acc_at[i] = -1; rsp_at[i] = -1; rdy_at[i] = -1;
        mpat[i] = {24'($urandom), md};
        rvalid[i] = 1; rwrite[i] = w; raddr[i] = a; rwdata[i] = d;
        wait_ev(i, 0);
        rvalid[i] = 0; rwrite[i] = !w; raddr[i] = ~a; rwdata[i] = ~d;
        wait_ev(i, 1);
        wait_ev(i, 2);
    endtask

    initial begin
        int t1;
        for (int i = 0; i < 3; i++) begin
            rstn[i] = 0; rvalid[i] = 0; rwrite[i] = 0; raddr[i] = '0; rwdata[i] = '0; miso[i] = 0;
            busy[i] = 0; wr[i] = 0; c0[i] = 0; exp_rd[i] = '0; mpat[i] = '0; mw[i] = '0; frame[i] = '0;
            prev_cs[i] = 1; prev_sclk[i] = 0; prev_mosi[i] = 0; prev_rdy[i] = 1; col[i] = '0;
            rises[i] = 0; cslow[i] = 0; viol[i] = 0; acc_at[i] = -1; rsp_at[i] = -1; rdy_at[i] = -1;
        end
        @(posedge clk); #1;
        repeat (3) cycle_();
        for (int i = 0; i < 3; i++) begin
            chk("rst_ready", i, rready[i], 1);
            chk("rst_cs_n", i, cs_n[i], 1);
            chk("rst_rdata", i, rsp_rdata[i], 0);
            rstn[i] = 1;
        end
        repeat (2) cycle_();

        xfer(0, 1, 10'h123, 16'hBEEF, 16'h0);
        chk("wr_frame", 0, col[0], 40'h80_0123_BEEF);
        chk("wr_pulses", 0, rises[0], 40);
        chk("wr_cs_low", 0, cslow[0], 162);
        chk("wr_rsp_time", 0, rsp_at[0] - acc_at[0], 163);
        chk("wr_ready_time", 0, rdy_at[0] - acc_at[0], 165);
        chk("wr_rdata", 0, rsp_rdata[0], 16'h0);
        chk("wr_mosi_stable", 0, viol[0], 0);

        xfer(0, 0, 10'h3FF, 16'hABCD, 16'h5555);
        chk("rd_frame", 0, col[0], 40'h00_03FF_0000);
        chk("rd_rdata", 0, rsp_rdata[0], 16'h5555);
        repeat (20) cycle_();
        chk("rd_rdata_held", 0, rsp_rdata[0], 16'h5555);

        acc_at[0] = -1; rsp_at[0] = -1;
        mpat[0] = {24'($urandom), 16'h1357};
        rvalid[0] = 1; rwrite[0] = 1; raddr[0] = 10'h0F0; rwdata[0] = 16'h5A5A;
        wait_ev(0, 0);
        t1 = acc_at[0]; acc_at[0] = -1;
        rwrite[0] = 0; raddr[0] = 10'h30C; rwdata[0] = 16'hFFFF; mpat[0] = {24'($urandom), 16'h2468};
        wait_ev(0, 1);
        chk("b2b_frame1", 0, col[0], 40'h80_00F0_5A5A);
        wait_ev(0, 0);
        chk("b2b_period", 0, acc_at[0] - t1, 165);
        rvalid[0] = 0; rsp_at[0] = -1;
        wait_ev(0, 1);
        chk("b2b_frame2", 0, col[0], 40'h00_030C_0000);
        chk("b2b_rdata", 0, rsp_rdata[0], 16'h2468);
        repeat (4) cycle_();

        xfer(1, 0, 10'h001, 16'h0, 16'hA5C3);
        chk("d1_rsp_time", 1, rsp_at[1] - acc_at[1], 82);
        chk("d1_rdata", 1, rsp_rdata[1], 16'hA5C3);
        chk("d1_pulses", 1, rises[1], 40);

        acc_at[0] = -1; rsp_at[0] = -1;
        rvalid[0] = 1; rwrite[0] = 1; raddr[0] = 10'h2AA; rwdata[0] = 16'h1234;
        wait_ev(0, 0);
        rvalid[0] = 0; t1 = acc_at[0];
        while (cyc < t1 + 81) cycle_();
        chk("pre_rst_cs_n", 0, cs_n[0], 0);
        rstn[0] = 0;
        #1;
        chk("mid_rst_cs_n", 0, cs_n[0], 1);
        chk("mid_rst_sclk", 0, sclk[0], 0);
        chk("mid_rst_mosi", 0, mosi[0], 0);
        chk("mid_rst_ready", 0, rready[0], 1);
        chk("mid_rst_rsp", 0, rsp_valid[0], 0);
        repeat (3) cycle_();
        rstn[0] = 1;
        repeat (200) cycle_();
        chk("no_rsp_after_rst", 0, rsp_at[0] < 0, 1);
        xfer(0, 1, 10'h155, 16'hC0DE, 16'h0);
        chk("post_rst_frame", 0, col[0], 40'h80_0155_C0DE);

        xfer(2, 0, 10'h2A5, 16'h7777, 16'h96F0);
        chk("d3_rdata", 2, rsp_rdata[2], 16'h96F0);
        chk("d3_rsp_time", 2, rsp_at[2] - acc_at[2], 244);
        chk("d3_frame", 2, col[2], 40'h00_02A5_0000);
        chk("d3_mosi_stable", 2, viol[2], 0);

        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 3; i++) begin
                rvalid[i] = $urandom_range(0, 3) != 0;
                rwrite[i] = 1'($urandom);
                raddr[i]  = 10'($urandom);
                rwdata[i] = 16'($urandom);
                mpat[i]   = {$urandom, 8'($urandom)};
            end
            cycle_();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
